// File: rtl/led_bank_arbiter.sv
// ----------------------------------------------------------------------------
// led_bank_arbiter
//
// Shares one 8-bit active-low LED bank between NREQ pattern generators.
// Ownership is granted round-robin with a minimum hold time so a displayed
// pattern stays readable. A PWM brightness stage gates the owner's pattern.
// The final LED drive is a flop so it can be packed into I/O registers.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   HOLD       minimum ownership in cycles before a competitor may preempt
//   PWM_DIV_W  log2 of the PWM slot length; the PWM period is 8 slots
//
// Ports
//   clk_125mhz  in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [NREQ]    level-sensitive ownership requests
//   led_data    in   [8*NREQ]  active-high pattern of requester i at [8*i +: 8]
//   brightness  in   [3]       duty setting, on-time is (brightness+1)/8
//   grant       out  [NREQ]    one-hot owner, all zero when idle
//   busy        out            high whenever grant is nonzero
//   led_n       out  [8]       active-low LED drive
// ----------------------------------------------------------------------------
module led_bank_arbiter #(
    parameter int NREQ      = 3,
    parameter int HOLD      = 1024,
    parameter int PWM_DIV_W = 4
) (
    input  logic                clk_125mhz,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   led_data,
    input  logic [2:0]          brightness,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [7:0]          led_n
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int PWM_W  = 3 + PWM_DIV_W;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);
    localparam logic [NREQ-1:0]   GRANT_0   = {NREQ{1'b0}};
    localparam logic [PWM_W-1:0]  PWM_ONE   = PWM_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [NREQ-1:0]    grant_q;
    logic               busy_q;
    logic [IDX_W-1:0]   last_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [7:0]         led_n_q;
    logic [7:0]         led_n_d;

    logic               pick_vld_s;
    logic [IDX_W-1:0]   pick_idx_s;
    int                 rr_cand_s;
    logic               owner_req_s;
    logic               other_pend_s;
    logic [7:0]         pat_s;
    logic               pwm_on_s;

    // One-hot encode a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == idx) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Round-robin pick: walk from the farthest candidate (last owner itself)
    // down to last+1, so the nearest requester after the last owner wins and
    // the last owner is only chosen when nobody else is asking.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = last_q;
        rr_cand_s  = 0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_cand_s = (int'(last_q) + k) % NREQ;
            if (req[rr_cand_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = IDX_W'(rr_cand_s);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Owner status and competitor detection against the registered grant.
    always_comb begin
        owner_req_s  = |(req & grant_q);
        other_pend_s = |(req & ~grant_q);
    end

    // Select the owner's pattern; grant is one-hot so an OR-mux suffices.
    always_comb begin
        pat_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                pat_s = pat_s | led_data[8*i +: 8];
            end else begin
                pat_s = pat_s;
            end
        end
    end

    // PWM gate and next LED drive; dark whenever nobody owns the bank.
    always_comb begin
        pwm_on_s = (pwm_cnt_q[PWM_W-1 -: 3] <= brightness);
        if (busy_q) begin
            led_n_d = ~(pat_s & {8{pwm_on_s}});
        end else begin
            led_n_d = 8'hFF;
        end
    end

    // Ownership state machine: grant, busy, last owner and hold counter.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_0;
            busy_q  <= 1'b0;
            last_q  <= LAST_RST;
            hold_q  <= HOLD_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_q <= ST_OWN;
                        grant_q <= onehot(pick_idx_s);
                        busy_q  <= 1'b1;
                        last_q  <= pick_idx_s;
                        hold_q  <= HOLD_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                        grant_q <= GRANT_0;
                        busy_q  <= 1'b0;
                        hold_q  <= HOLD_ZERO;
                    end
                end
                ST_OWN: begin
                    if (!owner_req_s) begin
                        // Owner let go: hand over regardless of hold time.
                        if (pick_vld_s) begin
                            grant_q <= onehot(pick_idx_s);
                            busy_q  <= 1'b1;
                            last_q  <= pick_idx_s;
                            hold_q  <= HOLD_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= GRANT_0;
                            busy_q  <= 1'b0;
                            hold_q  <= HOLD_ZERO;
                        end
                    end else if ((hold_q == HOLD_ZERO) && other_pend_s) begin
                        // Hold expired with a competitor waiting. The owner is
                        // last in the search, so the pick is the competitor.
                        grant_q <= onehot(pick_idx_s);
                        busy_q  <= 1'b1;
                        last_q  <= pick_idx_s;
                        hold_q  <= HOLD_LOAD;
                    end else if (hold_q == HOLD_ZERO) begin
                        // Sit at zero so a later competitor preempts at once.
                        hold_q <= HOLD_ZERO;
                    end else begin
                        hold_q <= hold_q - HOLD_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= GRANT_0;
                    busy_q  <= 1'b0;
                    last_q  <= LAST_RST;
                    hold_q  <= HOLD_ZERO;
                end
            endcase
        end
    end

    // Free-running PWM counter; wraps naturally at 8 slots.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= {PWM_W{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
        end
    end

    // LED output register, intended for placement at the pins.
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            led_n_q <= 8'hFF;
        end else begin
            led_n_q <= led_n_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign led_n = led_n_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_led_bank_arbiter
//
// Directed bench for led_bank_arbiter with NREQ=3, HOLD=4, PWM_DIV_W=4.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_led_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] led_data;
    logic [2:0]  brightness;
    logic [2:0]  grant;
    logic        busy;
    logic [7:0]  led_n;

    int          n_total;
    int          n_bad;
    int          n_on;
    int          n_other;
    logic [2:0]  exp_g;

    led_bank_arbiter #(
        .NREQ      (3),
        .HOLD      (4),
        .PWM_DIV_W (4)
    ) u_dut (
        .clk_125mhz (clk),
        .rst_n      (rst_n),
        .req        (req),
        .led_data   (led_data),
        .brightness (brightness),
        .grant      (grant),
        .busy       (busy),
        .led_n      (led_n)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pwm_count(input logic [2:0] b, input int exp_on);
        brightness = b;
        step();
        step();
        n_on    = 0;
        n_other = 0;
        for (int c = 0; c < 128; c++) begin
            step();
            if (led_n == 8'h00) begin
                n_on = n_on + 1;
            end else if (led_n != 8'hFF) begin
                n_other = n_other + 1;
            end
        end
        chk("pwm_on_cycles", 32'(n_on), 32'(exp_on));
        chk("pwm_partial", 32'(n_other), 32'd0);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b1;
        req        = 3'b000;
        led_data   = 24'h000000;
        brightness = 3'd7;

        // Reset state
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_led_n", 32'(led_n), 32'h0FF);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_grant", 32'(grant), 32'd0);

        // Single owner, full brightness
        led_data = {8'h81, 8'h3C, 8'h5A};
        req      = 3'b001;
        step();
        chk("single_grant", 32'(grant), 32'b001);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_led_lat", 32'(led_n), 32'h0FF);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("single_led", 32'(led_n), 32'h0A5);
            chk("single_hold", 32'(grant), 32'b001);
        end

        // Asynchronous reset while lit, checked before any clock edge
        rst_n = 1'b0;
        #1;
        chk("async_led_n", 32'(led_n), 32'h0FF);
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        req = 3'b011;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_prio", 32'(grant), 32'b001);

        // Round-robin under full contention
        rst_n = 1'b0;
        #1;
        req = 3'b111;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            exp_g = 3'b001 << ((k / 4) % 3);
            chk("rr_grant", 32'(grant), 32'(exp_g));
            chk("rr_busy", 32'(busy), 32'd1);
        end

        // Early release to idle
        rst_n = 1'b0;
        #1;
        req = 3'b000;
        step();
        rst_n = 1'b1;
        step();
        req = 3'b010;
        step();
        chk("early_grant", 32'(grant), 32'b010);
        step();
        chk("early_grant2", 32'(grant), 32'b010);
        chk("early_led", 32'(led_n), 32'h0C3);
        req = 3'b000;
        step();
        chk("early_idle", 32'(grant), 32'd0);
        chk("early_busy", 32'(busy), 32'd0);
        chk("early_led_lag", 32'(led_n), 32'h0C3);
        step();
        chk("early_dark", 32'(led_n), 32'h0FF);

        // Early release with another requester pending
        req = 3'b010;
        step();
        chk("handover_own", 32'(grant), 32'b010);
        step();
        req = 3'b100;
        step();
        chk("handover_direct", 32'(grant), 32'b100);
        chk("handover_busy", 32'(busy), 32'd1);
        step();
        chk("handover_led", 32'(led_n), 32'h07E);

        // Late competitor after a long uncontended hold
        req = 3'b001;
        step();
        chk("late_own", 32'(grant), 32'b001);
        repeat (2000) step();
        chk("late_hold", 32'(grant), 32'b001);
        req = 3'b011;
        step();
        chk("late_preempt", 32'(grant), 32'b010);

        // Pattern change shows one edge later
        req            = 3'b010;
        led_data[15:8] = 8'h0F;
        step();
        chk("data_update", 32'(led_n), 32'h0F0);

        // PWM duty over one full 128-cycle period
        led_data[15:8] = 8'hFF;
        pwm_count(3'd0, 16);
        pwm_count(3'd3, 64);
        pwm_count(3'd7, 128);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Shares the board's single 8-bit active-low LED bank between up to NREQ independent requesters, such as a blinky counter, a status display and a self-test pattern. Ownership is granted round-robin, with a minimum hold time so displayed patterns stay readable. A PWM brightness stage runs on the granted pattern. The output is registered so the final flops can be placed as I/O registers at the LED pins. The block sits between the requesting pattern generators and the top-level `led_*` outputs.

## Interface

Parameters:
- NREQ, 3: number of requesters; 2..8.
- HOLD, 1024: minimum ownership in cycles before another requester may preempt; ≥1.
- PWM_DIV_W, 4: PWM slot length is 2^PWM_DIV_W cycles. The PWM period is 8 slots.

Ports (one clock; reset is asynchronous and active-low):
- clk_125mhz  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to clk_125mhz (synchronized upstream).
- req  input  NREQ  per-requester ownership request, level-sensitive.
- led_data  input  8*NREQ  active-high pattern for requester i at bits [8*i +: 8].
- brightness  input  3  global duty setting; on-time is (brightness+1)/8.
- grant  output  NREQ  one-hot owner, or all zero when idle.
- busy  output  1  high whenever grant is nonzero.
- led_n  output  8  active-low LED drive. A 0 bit lights the LED.

## Operation

- State machine:
  - IDLE: grant=0, led_n=8'hFF.
  - OWN: exactly one grant bit set.
- Round-robin selection:
  - Search begins at index (last_owner+1) mod NREQ and wraps.
  - last_owner is considered last.
  - last_owner resets to NREQ-1, so req[0] has first priority after reset.
- IDLE → OWN:
  - Triggered when any req bit is high.
  - Load the selected index into grant and last_owner.
  - Load hold_cnt with HOLD-1.
- In OWN, hold_cnt decrements each cycle and saturates at 0.
- Owner release:
  - Owner drops req: on the next edge, grant moves to the next requester in round-robin order (hold_cnt reloads), or goes to IDLE if none are pending. This is independent of hold_cnt.
  - hold_cnt==0, owner still requesting, another req pending: preempt. Grant moves directly to the next requester in round-robin order and hold_cnt reloads.
  - hold_cnt==0, no other req pending: keep the grant. hold_cnt stays 0, so preemption is immediate once a competitor appears.
- Handover is direct from one one-hot value to another, with no idle cycle in between.
- PWM:
  - Free-running counter pwm_cnt, width 3+PWM_DIV_W, wraps naturally.
  - slot = pwm_cnt[top 3 bits].
  - pwm_on = (slot ≤ brightness).
- Output register: led_n ← busy ? ~(led_data[owner] & {8{pwm_on}}) : 8'hFF, using registered grant/owner.
- Reset values: grant=0, busy=0, led_n=8'hFF, hold_cnt=0, pwm_cnt=0, last_owner=NREQ-1.
- Reset asserted mid-operation clears all state immediately. LEDs go dark without waiting for a clock.

## Timing

- req rising at edge E (sampled at E) → grant set at E → led_n reflects the pattern at E+1.
- led_data or brightness change → led_n updates one edge later.
- Uncontended preemption point: an owner granted at E0 is replaced at edge E0+HOLD. Under continuous contention, each owner holds for exactly HOLD cycles.
- Owner req drop sampled at E → grant changes at E → led_n changes at E+1.
- brightness changes take effect at the next edge, with no waiting for the PWM period boundary.
- No combinational path from any input to any output.

## Test plan

- Reset: assert rst_n=0 while owning with a lit pattern → led_n=8'hFF, grant=0, busy=0 immediately (asynchronously). After release, req[0] wins over req[1] when both are asserted together.
- Single owner: req=001, led_data[7:0]=8'h5A, brightness=7 → grant=001 one edge after req, then led_n=8'hA5 constantly one edge after that.
- Round-robin, HOLD=4, req=111 held → grant sequence 001×4, 010×4, 100×4, 001×4 … with no gap cycles. Includes wrap from index 2 to 0.
- Early release, HOLD=1024: req=010 for 2 cycles, then 000 → grant=000 and busy=0 on the edge after the drop, led_n=8'hFF one edge later. Repeat with req[2] pending → grant goes directly to 100.
- Late competitor: req0 alone for 2000 cycles, then req1 asserts → grant switches to 010 on the first edge that samples req1. hold_cnt has already expired.
- PWM, PWM_DIV_W=4, led_data=8'hFF:
  - brightness=0 → led_n=8'h00 for 16 of every 128 cycles, 8'hFF otherwise.
  - brightness=3 → led_n=8'h00 for 64 of every 128 cycles.
